// File: rtl/alu_a.sv
// alu_a: 8-bit registered ALU with N/Z/V/C flags, one-cycle latency.
// Optional feature: define ALU_A_SATURATE_EN to clamp signed-overflowing
// ADD/INC/SUB/DEC results to 8'h7F / 8'h80 (V and C still report raw values).
module alu_a (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] sel,
    output logic [7:0] result,
    output logic [3:0] NZVC
);

    localparam logic [2:0] SelAdd = 3'd0;
    localparam logic [2:0] SelInc = 3'd1;
    localparam logic [2:0] SelSub = 3'd2;
    localparam logic [2:0] SelDec = 3'd3;
    localparam logic [2:0] SelAnd = 3'd4;
    localparam logic [2:0] SelOr  = 3'd5;
    localparam logic [2:0] SelXor = 3'd6;
    localparam logic [2:0] SelNot = 3'd7;

    logic [7:0] r_result;
    logic [3:0] r_nzvc;

    logic [7:0] w_opb;
    logic [8:0] w_sum9;
    logic [8:0] w_diff9;
    logic       w_add_v;
    logic       w_sub_v;
    logic [7:0] w_res;
    logic       w_v;
    logic       w_c;
    logic       w_arith;

    // Second arithmetic operand: B for ADD/SUB, constant 1 for INC/DEC
    always_comb begin
        w_opb = B;
        if (sel == SelInc || sel == SelDec) begin
            w_opb = 8'h01;
        end
    end

    assign w_sum9  = {1'b0, A} + {1'b0, w_opb};
    assign w_diff9 = {1'b0, A} - {1'b0, w_opb};
    // Bit 8 of the 9-bit difference is the unsigned borrow
    assign w_add_v = (A[7] == w_opb[7]) && (w_sum9[7] != A[7]);
    assign w_sub_v = (A[7] != w_opb[7]) && (w_diff9[7] != A[7]);

    // Operation decode: raw result and V/C flags
    always_comb begin
        w_res   = 8'h00;
        w_v     = 1'b0;
        w_c     = 1'b0;
        w_arith = 1'b0;
        unique case (sel)
            SelAdd, SelInc: begin
                w_res   = w_sum9[7:0];
                w_v     = w_add_v;
                w_c     = w_sum9[8];
                w_arith = 1'b1;
            end
            SelSub, SelDec: begin
                w_res   = w_diff9[7:0];
                w_v     = w_sub_v;
                w_c     = w_diff9[8];
                w_arith = 1'b1;
            end
            SelAnd: w_res = A & B;
            SelOr:  w_res = A | B;
            SelXor: w_res = A ^ B;
            SelNot: w_res = ~A;
            default: w_res = 8'h00;
        endcase
`ifdef ALU_A_SATURATE_EN
        // On overflow the true result carries A's sign, which picks the clamp direction
        if (w_arith && w_v) begin
            w_res = A[7] ? 8'h80 : 8'h7F;
        end
`else
        w_arith = w_arith;
`endif
    end

    // Register result and flags; reset has priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 8'h00;
            r_nzvc   <= 4'b0000;
        end else begin
            r_result <= w_res;
            r_nzvc   <= {w_res[7], (w_res == 8'h00), w_v, w_c};
        end
    end

    assign result = r_result;
    assign NZVC   = r_nzvc;

endmodule

// File: tb/tb_alu_a.sv
// Scoreboard bench for alu_a: stimulus pushes expected values, a monitor pops and checks.
module tb_alu_a;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] sel;
    logic [7:0] result;
    logic [3:0] NZVC;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic [3:0] flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    bit   done;

    alu_a u_dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .sel    (sel),
        .result (result),
        .NZVC   (NZVC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus on the falling edge and queue its expected outcome
    task automatic issue(input string name, input logic r, input logic [2:0] s,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        rst = r;
        sel = s;
        A   = a;
        B   = b;
        e.name  = name;
        e.res   = er;
        e.flags = ef;
        exp_q.push_back(e);
    endtask

    // Monitor: every registered output is compared against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (result !== e.res || NZVC !== e.flags) begin
                    n_fail++;
                    $display("FAIL %s: got result=%h NZVC=%b, expected result=%h NZVC=%b",
                             e.name, result, NZVC, e.res, e.flags);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done     = 1'b0;
        rst = 1'b1;
        A   = 8'h00;
        B   = 8'h00;
        sel = 3'd0;
        @(negedge clk);

        // Reset, then first result one edge after release
        issue("reset",      1'b1, 3'd0, 8'h55, 8'h01, 8'h00, 4'b0000);
        issue("first_add",  1'b0, 3'd0, 8'h55, 8'h01, 8'h56, 4'b0000);

        // ADD
`ifdef ALU_A_SATURATE_EN
        issue("add_ovf",    1'b0, 3'd0, 8'd100, 8'd30, 8'h7F, 4'b0010);
`else
        issue("add_ovf",    1'b0, 3'd0, 8'd100, 8'd30, 8'h82, 4'b1010);
`endif
        issue("add_neg",    1'b0, 3'd0, 8'd100, 8'h88, 8'hEC, 4'b1000);
        issue("add_small",  1'b0, 3'd0, 8'd1,   8'd5,  8'h06, 4'b0000);

        // INC (B is garbage to show it is ignored)
`ifdef ALU_A_SATURATE_EN
        issue("inc_ovf",    1'b0, 3'd1, 8'd127, 8'hA5, 8'h7F, 4'b0010);
`else
        issue("inc_ovf",    1'b0, 3'd1, 8'd127, 8'hA5, 8'h80, 4'b1010);
`endif
        issue("inc_carry",  1'b0, 3'd1, 8'hFF,  8'h3C, 8'h00, 4'b0101);
        issue("inc_neg",    1'b0, 3'd1, 8'hF6,  8'hFF, 8'hF7, 4'b1000);

        // SUB
        issue("sub_borrow", 1'b0, 3'd2, 8'd17,  8'd40, 8'hE9, 4'b1001);
`ifdef ALU_A_SATURATE_EN
        issue("sub_ovf",    1'b0, 3'd2, 8'd73,  8'hA3, 8'h7F, 4'b0011);
`else
        issue("sub_ovf",    1'b0, 3'd2, 8'd73,  8'hA3, 8'hA6, 4'b1011);
`endif
        issue("sub_plain",  1'b0, 3'd2, 8'd73,  8'd40, 8'h21, 4'b0000);

        // DEC
`ifdef ALU_A_SATURATE_EN
        issue("dec_ovf",    1'b0, 3'd3, 8'h80,  8'h77, 8'h80, 4'b1010);
`else
        issue("dec_ovf",    1'b0, 3'd3, 8'h80,  8'h77, 8'h7F, 4'b0010);
`endif
        issue("dec_zero",   1'b0, 3'd3, 8'd1,   8'hFF, 8'h00, 4'b0100);

        // Logic ops
        issue("and",        1'b0, 3'd4, 8'd78,  8'd121, 8'h48, 4'b0000);
        issue("or",         1'b0, 3'd5, 8'h81,  8'h02, 8'h83, 4'b1000);
        issue("xor",        1'b0, 3'd6, 8'h00,  8'hFF, 8'hFF, 4'b1000);
        issue("xor_zero",   1'b0, 3'd6, 8'h5A,  8'h5A, 8'h00, 4'b0100);
        issue("not",        1'b0, 3'd7, 8'hFF,  8'h12, 8'h00, 4'b0100);
        issue("not_neg",    1'b0, 3'd7, 8'h00,  8'h00, 8'hFF, 4'b1000);

        // Reset in the middle of a stream has priority, then operation resumes
        issue("mid_reset",  1'b1, 3'd2, 8'd17,  8'd40, 8'h00, 4'b0000);
        issue("post_reset", 1'b0, 3'd0, 8'h80,  8'h80, 8'h00, 4'b0111);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
